// File: rtl/median_window_addr_gen_if.sv
// Window tap address channel from the scan controller to pixel memory.
// Valid/ready handshake; addr/tap/last_tap are held until accepted.
interface median_window_addr_gen_if #(
  parameter int ADDR_WIDTH = 18
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            tap;
  logic                  addr_valid;
  logic                  addr_ready;
  logic                  last_tap;

  modport master (
    output addr,
    output tap,
    output addr_valid,
    output last_tap,
    input  addr_ready
  );

  modport slave (
    input  addr,
    input  tap,
    input  addr_valid,
    input  last_tap,
    output addr_ready
  );
endinterface

// File: rtl/median_window_addr_gen.sv
// Raster scan controller issuing the nine 3x3 neighbourhood read addresses
// per output pixel, with edge replication, driving the row-base accumulator.
module median_window_addr_gen #(
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  input  logic [ADDR_WIDTH-1:0] row_based,
  output logic                  row_based_clear,
  output logic                  row_based_update,
  output logic                  busy,
  output logic                  frame_done,
  median_window_addr_gen_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EMIT,
    S_ROW_ADV,
    S_ROW_WAIT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [DIM_WIDTH-1:0]  x_q;
  logic [DIM_WIDTH-1:0]  y_q;
  logic [3:0]            tap_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_valid_q;
  logic                  last_tap_q;
  logic                  clear_q;
  logic                  update_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  last_col;
  logic                  last_row;
  logic                  accept;

  assign last_col = (x_q == width - DIM_WIDTH'(1));
  assign last_row = (y_q == height - DIM_WIDTH'(1));
  assign accept   = addr_valid_q && mem.addr_ready;

  // Address of tap t of pixel (x, y), given the row base of row y.
  function automatic logic [ADDR_WIDTH-1:0] tap_addr(
    input logic [DIM_WIDTH-1:0]  x,
    input logic [DIM_WIDTH-1:0]  y,
    input logic [3:0]            t,
    input logic [ADDR_WIDTH-1:0] rb
  );
    logic [1:0]            dy_sel;
    logic [1:0]            dx_sel;
    logic [DIM_WIDTH-1:0]  xc;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] w_ext;
    w_ext = ADDR_WIDTH'(width);
    case (t)
      4'd0, 4'd1, 4'd2: dy_sel = 2'd0;
      4'd3, 4'd4, 4'd5: dy_sel = 2'd1;
      default:          dy_sel = 2'd2;
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: dx_sel = 2'd0;
      4'd1, 4'd4, 4'd7: dx_sel = 2'd1;
      default:          dx_sel = 2'd2;
    endcase
    case (dx_sel)
      2'd0:    xc = (x == '0) ? x : x - DIM_WIDTH'(1);
      2'd1:    xc = x;
      default: xc = (x == width - DIM_WIDTH'(1)) ? x : x + DIM_WIDTH'(1);
    endcase
    case (dy_sel)
      2'd0:    base = (y != '0) ? rb - w_ext : rb;
      2'd1:    base = rb;
      default: base = (y != height - DIM_WIDTH'(1)) ? rb + w_ext : rb;
    endcase
    return base + ADDR_WIDTH'(xc);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      tap_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      last_tap_q   <= 1'b0;
      clear_q      <= 1'b0;
      update_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      clear_q  <= 1'b0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (width == '0 || height == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              x_q     <= '0;
              y_q     <= '0;
              tap_q   <= '0;
              clear_q <= 1'b1;
              state_q <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          // The accumulator is being cleared this cycle, so row 0 has base 0.
          addr_q       <= tap_addr(x_q, y_q, 4'd0, '0);
          tap_q        <= '0;
          last_tap_q   <= 1'b0;
          addr_valid_q <= 1'b1;
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (accept) begin
            if (tap_q != 4'd8) begin
              tap_q      <= tap_q + 4'd1;
              last_tap_q <= (tap_q == 4'd7);
              addr_q     <= tap_addr(x_q, y_q, tap_q + 4'd1, row_based);
            end else if (!last_col) begin
              x_q        <= x_q + DIM_WIDTH'(1);
              tap_q      <= '0;
              last_tap_q <= 1'b0;
              addr_q     <= tap_addr(x_q + DIM_WIDTH'(1), y_q, 4'd0, row_based);
            end else begin
              addr_valid_q <= 1'b0;
              tap_q        <= '0;
              last_tap_q   <= 1'b0;
              addr_q       <= '0;
              if (!last_row) begin
                update_q <= 1'b1;
                state_q  <= S_ROW_ADV;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
        end
        S_ROW_ADV: begin
          x_q     <= '0;
          y_q     <= y_q + DIM_WIDTH'(1);
          state_q <= S_ROW_WAIT;
        end
        S_ROW_WAIT: begin
          // row_based now reflects the update issued in ROW_ADV.
          addr_q       <= tap_addr(x_q, y_q, 4'd0, row_based);
          addr_valid_q <= 1'b1;
          state_q      <= S_EMIT;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.addr         = addr_q;
  assign mem.tap          = tap_q;
  assign mem.addr_valid   = addr_valid_q;
  assign mem.last_tap     = last_tap_q;
  assign row_based_clear  = clear_q;
  assign row_based_update = update_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;

endmodule

// File: doc/median_window_addr_gen.md
# median_window_addr_gen

Scan controller and 3x3 window address generator for the median filter unit. Walks the image in raster order and, for each output pixel, issues the nine neighbourhood read addresses to pixel memory through a valid/ready handshake, with edge replication at image borders. It drives the row-base accumulator's `row_based_clear` / `row_based_update` controls and consumes the accumulated `row_based` value as the current row's base address.

## Interface
- `ADDR_WIDTH`, default 18 (from `common.vh`): pixel memory address width.
- `DIM_WIDTH`, default 10: width of the image dimension inputs.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, **asynchronous, active-high**.
- `start` in 1: one-cycle request to scan a frame; ignored while `busy`.
- `width` in DIM_WIDTH: image width in pixels; held stable while `busy`.
- `height` in DIM_WIDTH: image height in pixels; held stable while `busy`.
- `row_based` in ADDR_WIDTH: current row base (y*width) from the row-base accumulator.
- `row_based_clear` out 1: clear pulse to the accumulator.
- `row_based_update` out 1: add-width pulse to the accumulator.
- `addr` out ADDR_WIDTH: window tap read address.
- `tap` out 4: tap index 0..8 of `addr`.
- `addr_valid` out 1: `addr`/`tap` valid.
- `addr_ready` in 1: memory side accepts the address.
- `last_tap` out 1: high with tap 8.
- `busy` out 1: a frame scan is in progress.
- `frame_done` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, CLEAR, EMIT, ROW_ADV, ROW_WAIT, DONE.
- IDLE: all outputs 0. On `start`:
  - if width==0 or height==0, go to DONE;
  - otherwise capture x=0, y=0, tap=0 and go to CLEAR.
- CLEAR: `row_based_clear`=1 for one cycle; then EMIT.
- EMIT:
  - `addr_valid`=1; tap advances on `addr_valid && addr_ready`.
  - After tap 8 is accepted:
    - if x<width-1: x++, tap=0, stay in EMIT;
    - else if y<height-1: go to ROW_ADV;
    - else go to DONE.
- ROW_ADV: `row_based_update`=1 for one cycle; x=0, y++, tap=0; then ROW_WAIT.
- ROW_WAIT: one idle cycle so the accumulator output settles; then EMIT.
- DONE: `frame_done`=1 for one cycle; then IDLE.
- `busy`=1 in every state except IDLE.
- Tap order: tap = 3*(dy+1) + (dx+1), with dy, dx each in {-1, 0, +1}; dy is the outer loop.
- Column: xc = clamp(x+dx, 0, width-1).
- Row base:
  - dy=-1: `row_based`-width if y>0, else `row_based`;
  - dy=0: `row_based`;
  - dy=+1: `row_based`+width if y<height-1, else `row_based`.
- `addr` = row base + xc. All arithmetic is ADDR_WIDTH bits with width zero-extended.
- width*height must be ≤ 2^ADDR_WIDTH; if it is larger, addresses wrap modulo 2^ADDR_WIDTH (no error flag).
- width==1: every xc is 0. height==1: every row base is `row_based`.

## Timing
- Reset value of every output is 0; state returns to IDLE.
- RST asserted mid-frame aborts immediately: no `frame_done`, and no further clear/update pulses.
- `addr`, `tap`, `last_tap` are registered. They stay stable while `addr_valid && !addr_ready` and change only after an accepted handshake.
- `addr_valid` never drops without acceptance while in EMIT.
- `start` sampled at cycle 0:
  - CLEAR at cycle 1;
  - first `addr_valid` at cycle 2, with `row_based`=0 visible.
- With `addr_ready` held at 1:
  - one tap per cycle;
  - 9 cycles per pixel;
  - 2 extra cycles per row change (ROW_ADV + ROW_WAIT).
- `frame_done` asserts in the cycle after the final tap-8 handshake. `busy` falls the following cycle.
- `row_based_update` is never issued on the last row. Exactly height-1 pulses occur per frame, and exactly one `row_based_clear`.
- `start` while `busy` has no effect. `start` in the same cycle as `frame_done` is ignored.
- Degenerate start (width==0 or height==0): `frame_done` pulses at cycle 1; no addresses and no clear pulse are issued.

## Test plan
- width=4, height=3, `addr_ready`=1, bench models the accumulator:
  - pixel (0,0) taps = 0,0,1,0,0,1,4,4,5;
  - pixel (1,1) taps = 0,1,2,4,5,6,8,9,10;
  - pixel (3,2) taps = 6,7,7,10,11,11,10,11,11;
  - 108 handshakes total, 2 update pulses, 1 clear, a single `frame_done`.
- Backpressure: same frame, `addr_ready` held low 5 cycles while tap=4 of pixel (1,1):
  - `addr` stays 5 and `tap` stays 4 throughout;
  - address sequence is identical to the previous test.
- width=1, height=1: nine taps all at `addr`=0; `last_tap` on tap 8; no update pulse; `frame_done` one cycle later.
- width=0, height=5: `frame_done` at cycle 1, `addr_valid` never asserted, `busy` high for exactly 1 cycle.
- RST pulsed during pixel (2,1) of a 4x3 frame:
  - all outputs 0 asynchronously, IDLE;
  - a subsequent `start` restarts from `addr`=0 with a fresh clear pulse.
- `start` re-asserted mid-frame and again in the `frame_done` cycle: neither affects the sequence; 108 handshakes and one `frame_done` only.
